bsg_link_credit_serializer_tx: RTL and testbench

Single-clock, credit-flow-controlled transmit end of the off-chip link: accepts full core words on a valid/ready interface and serializes each into narrow channel beats. It consumes credits that the receiving end returns as token pulses. It sits between the core and the link pins, opposite the downstream receiver whose token output it counts. Credits are tracked in whole words, so the receiver buffer can never overflow.

---
 rtl/bsg_link_credit_serializer_tx.sv | 95 +++++++++
 tb/tb_bsg_link_credit_serializer_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_credit_serializer_tx.sv
// Transmit end of the credit-flow-controlled off-chip link: takes full core
// words on valid/ready, sends them as narrow channel beats, spends one credit per word.
module bsg_link_credit_serializer_tx #(
   parameter int width_p               = 64,
   parameter int channel_width_p       = 16,
   parameter int credit_max_p          = 8,
   parameter int lg_token_decimation_p = 0
) (
   input  logic                               core_clk_i,
   input  logic                               core_reset_n_i,
   input  logic [width_p-1:0]                 core_data_i,
   input  logic                               core_valid_i,
   output logic                               core_ready_o,
   output logic [channel_width_p-1:0]         io_data_o,
   output logic                               io_valid_o,
   input  logic                               token_i,
   output logic [$clog2(credit_max_p+1)-1:0]  credit_count_o,
   output logic                               credit_overflow_o
);

   localparam int beats_lp  = width_p / channel_width_p;
   localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
   localparam int cnt_w_lp  = $clog2(credit_max_p + 1);

   localparam logic [beat_w_lp-1:0] last_beat_lp  = beat_w_lp'(beats_lp - 1);
   localparam logic [cnt_w_lp:0]    token_amt_lp  = (cnt_w_lp+1)'(2 ** lg_token_decimation_p);
   localparam logic [cnt_w_lp:0]    credit_max_lp = (cnt_w_lp+1)'(credit_max_p);

   localparam logic [0:0] idle_s = 1'b0;
   localparam logic [0:0] send_s = 1'b1;

   logic [0:0]                                state_r;
   logic [beat_w_lp-1:0]                      beat_r;
   logic [beats_lp-1:0][channel_width_p-1:0]  shift_r;
   logic [cnt_w_lp-1:0]                       credit_r;
   logic                                      overflow_r;
   logic                                      last_beat;
   logic                                      accept;
   logic [cnt_w_lp:0]                         credit_sum;

   assign last_beat = (beat_r == last_beat_lp);

   // Ready depends only on registers, so the core never sees a valid->ready loop.
   assign core_ready_o = (credit_r != '0)
                       & ((state_r == idle_s) | ((state_r == send_s) & last_beat));
   assign accept       = core_valid_i & core_ready_o;

   // One bit wider than the counter so an over-return is detectable before saturation.
   assign credit_sum = {1'b0, credit_r}
                     - (cnt_w_lp+1)'(accept)
                     + (token_i ? token_amt_lp : '0);

   always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         state_r    <= idle_s;
         beat_r     <= '0;
         shift_r    <= '0;
         io_valid_o <= 1'b0;
         io_data_o  <= '0;
      end else begin
         io_valid_o <= (state_r == send_s);
         if (state_r == send_s)
            io_data_o <= shift_r[beat_r];

         if (accept) begin
            shift_r <= core_data_i;
            beat_r  <= '0;
            state_r <= send_s;
         end else if (state_r == send_s) begin
            if (last_beat) begin
               state_r <= idle_s;
               beat_r  <= '0;
            end else begin
               beat_r  <= beat_r + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         credit_r   <= cnt_w_lp'(credit_max_p);
         overflow_r <= 1'b0;
      end else if (credit_sum > credit_max_lp) begin
         credit_r   <= cnt_w_lp'(credit_max_p);
         overflow_r <= 1'b1;
      end else begin
         credit_r   <= credit_sum[cnt_w_lp-1:0];
      end
   end

   assign credit_count_o    = credit_r;
   assign credit_overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_link_credit_serializer_tx.sv
// Directed bench for bsg_link_credit_serializer_tx at default parameters.
module tb_bsg_link_credit_serializer_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] core_data;
   logic        core_valid;
   logic        core_ready;
   logic [15:0] io_data;
   logic        io_valid;
   logic        token;
   logic [3:0]  credit;
   logic        ovf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bsg_link_credit_serializer_tx dut (
      .core_clk_i        (clk),
      .core_reset_n_i    (rst_n),
      .core_data_i       (core_data),
      .core_valid_i      (core_valid),
      .core_ready_o      (core_ready),
      .io_data_o         (io_data),
      .io_valid_o        (io_valid),
      .token_i           (token),
      .credit_count_o    (credit),
      .credit_overflow_o (ovf)
   );

   typedef struct {
      logic        valid;
      logic [63:0] data;
      logic        token;
      logic        exp_ready;
      logic        exp_vld;
      logic [15:0] exp_data;
      logic [3:0]  exp_credit;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic t);
      @(negedge clk);
      core_valid = v;
      core_data  = d;
      token      = t;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      core_valid = 1'b0;
      token      = 1'b0;
      core_data  = '0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   // Accept one word from IDLE and let its four beats drain back to IDLE.
   task automatic send_idle_word(input logic [63:0] w);
      drive(1'b1, w, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b0);
         tick();
      end
   endtask

   function automatic logic [63:0] mk_word(input int i);
      logic [63:0] w;
      for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'(i * 256 + k);
      return w;
   endfunction

   initial begin
      logic [63:0] w1;
      logic [15:0] q[$];
      logic [15:0] expb;
      int          n_acc, n_beats, first_c, last_c;
      logic        acc;

      w1 = 64'h0123_4567_89AB_CDEF;
      //            valid data token ready vld  data      credit
      tbl[0] = '{1'b1, w1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd7};
      tbl[1] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 16'hCDEF, 4'd7};
      tbl[2] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h89AB, 4'd7};
      tbl[3] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h4567, 4'd7};
      tbl[4] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 16'h0123, 4'd7};
      tbl[5] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h0123, 4'd7};
      tbl[6] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h0123, 4'd7};

      rst_n = 1'b1; core_valid = 1'b0; token = 1'b0; core_data = '0;
      do_reset();
      chk("rst_ready",  core_ready, 1);
      chk("rst_vld",    io_valid,   0);
      chk("rst_data",   io_data,    0);
      chk("rst_credit", credit,     8);
      chk("rst_ovf",    ovf,        0);

      // Single word, cycle by cycle
      foreach (tbl[i]) begin
         drive(tbl[i].valid, tbl[i].data, tbl[i].token);
         chk($sformatf("single_ready[%0d]", i), core_ready, tbl[i].exp_ready);
         tick();
         chk($sformatf("single_vld[%0d]", i), io_valid, tbl[i].exp_vld);
         if (tbl[i].exp_vld)
            chk($sformatf("single_data[%0d]", i), io_data, tbl[i].exp_data);
         chk($sformatf("single_credit[%0d]", i), credit, tbl[i].exp_credit);
      end

      // Continuous valid from full credits, no tokens
      do_reset();
      n_acc = 0; n_beats = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 45; c++) begin
         drive(1'b1, mk_word(n_acc), 1'b0);
         acc = core_ready;
         tick();
         if (acc) begin
            for (int k = 0; k < 4; k++) q.push_back(16'(n_acc * 256 + k));
            n_acc++;
         end
         if (io_valid) begin
            n_beats++;
            if (first_c < 0) first_c = c;
            last_c = c;
            if (q.size() == 0) chk("burst_underrun", 1, 0);
            else begin
               expb = q.pop_front();
               if (io_data !== expb) chk($sformatf("burst_data[%0d]", c), io_data, expb);
            end
         end
      end
      chk("burst_accepts",   n_acc,   8);
      chk("burst_beats",     n_beats, 32);
      chk("burst_contig",    last_c - first_c + 1, 32);
      chk("burst_credit",    credit,  0);
      chk("burst_ready",     core_ready, 0);
      chk("burst_vld_drop",  io_valid, 0);

      // Starvation recovery: one token at count 0 buys exactly one word
      drive(1'b1, w1, 1'b1);
      chk("starve_ready0", core_ready, 0);
      tick();
      chk("starve_credit1", credit, 1);
      drive(1'b1, w1, 1'b0);
      chk("starve_ready1", core_ready, 1);
      tick();
      chk("starve_credit0", credit, 0);
      n_acc = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, mk_word(99), 1'b0);
         if (core_ready) n_acc++;
         tick();
         if (k < 4) begin
            chk($sformatf("starve_vld[%0d]", k), io_valid, 1);
            expb = w1[k*16 +: 16];
            chk($sformatf("starve_data[%0d]", k), io_data, expb);
         end
      end
      chk("starve_no_more", n_acc, 0);
      chk("starve_credit_end", credit, 0);

      // Token and accept together at count 5
      do_reset();
      for (int i = 0; i < 3; i++) send_idle_word(mk_word(i));
      chk("pre5_credit", credit, 5);
      drive(1'b1, w1, 1'b1);
      chk("tokacc_ready", core_ready, 1);
      tick();
      chk("tokacc_credit", credit, 5);
      chk("tokacc_ovf", ovf, 0);
      drive(1'b0, '0, 1'b0);
      tick();
      chk("tokacc_beat0", io_data, 16'hCDEF);

      // Overflow: token at full credits is sticky until reset
      do_reset();
      drive(1'b0, '0, 1'b1);
      tick();
      chk("ovf_credit", credit, 8);
      chk("ovf_flag", ovf, 1);
      send_idle_word(w1);
      chk("ovf_sticky", ovf, 1);
      chk("ovf_credit_after", credit, 7);
      do_reset();
      chk("ovf_cleared", ovf, 0);

      // Reset during beat 2, then a clean word
      drive(1'b1, w1, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, '0, 1'b0);
         tick();
      end
      chk("mid_beat2", io_data, 16'h4567);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld",    io_valid,   0);
      chk("mid_rst_credit", credit,     8);
      chk("mid_rst_ready",  core_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, mk_word(7), 1'b0);
      tick();
      chk("post_credit", credit, 7);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, '0, 1'b0);
         tick();
         chk($sformatf("post_vld[%0d]", k), io_valid, 1);
         chk($sformatf("post_data[%0d]", k), io_data, 16'(7 * 256 + k));
      end
      drive(1'b0, '0, 1'b0);
      tick();
      chk("post_idle", io_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
